// File: rtl/core_lsu_ahb_master_pkg.sv
// Shared encodings and helpers for the LSU to AHB-Lite master bridge.
package core_lsu_ahb_master_pkg;

  localparam int unsigned XLEN = 32;

  // LSU func3 width codes
  localparam logic [2:0] LS_B  = 3'b000;
  localparam logic [2:0] LS_H  = 3'b001;
  localparam logic [2:0] LS_W  = 3'b010;
  localparam logic [2:0] LS_BU = 3'b100;
  localparam logic [2:0] LS_HU = 3'b101;

  // AHB-Lite encodings
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic       HRESP_OKAY    = 1'b0;
  localparam logic       HRESP_ERROR   = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } lsu_state_e;

  typedef struct packed {
    logic            err;
    logic [XLEN-1:0] rdata;
  } lsu_resp_t;

  // Undefined func3 codes fall into the word size.
  function automatic logic [2:0] ahb_size(input logic [2:0] rwtyp);
    case (rwtyp[1:0])
      2'b00:   return 3'b000;
      2'b01:   return 3'b001;
      default: return 3'b010;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [2:0] rwtyp, input logic [1:0] addr_lo);
    case (ahb_size(rwtyp))
      3'b001:  return addr_lo[0];
      3'b010:  return |addr_lo;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] lane_data(input logic [2:0] rwtyp, input logic [XLEN-1:0] wdata);
    case (ahb_size(rwtyp))
      3'b000:  return {4{wdata[7:0]}};
      3'b001:  return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

endpackage

// File: rtl/core_lsu_load_align.sv
// Selects the addressed byte/half of the read bus and sign- or zero-extends it.
module core_lsu_load_align
  import core_lsu_ahb_master_pkg::*;
(
  input  logic [XLEN-1:0] hrdata,
  input  logic [1:0]      addr_lo,
  input  logic [2:0]      rwtyp,
  output logic [XLEN-1:0] rdata_c
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = hrdata[7:0];
    case (addr_lo)
      2'd1:    byte_sel = hrdata[15:8];
      2'd2:    byte_sel = hrdata[23:16];
      2'd3:    byte_sel = hrdata[31:24];
      default: byte_sel = hrdata[7:0];
    endcase
    half_sel = addr_lo[1] ? hrdata[31:16] : hrdata[15:0];

    case (rwtyp)
      LS_B:    rdata_c = {{24{byte_sel[7]}}, byte_sel};
      LS_BU:   rdata_c = {24'h0, byte_sel};
      LS_H:    rdata_c = {{16{half_sel[15]}}, half_sel};
      LS_HU:   rdata_c = {16'h0, half_sel};
      default: rdata_c = hrdata;
    endcase
  end

endmodule

// File: rtl/core_lsu_ahb_master.sv
// LSU request/response handshake to AHB-Lite master: one SINGLE transfer at a time,
// loads answered through a one-entry response register, stores fire-and-forget.
module core_lsu_ahb_master
  import core_lsu_ahb_master_pkg::*;
#(
  parameter int unsigned     CHECK_ALIGN = 1,
  parameter logic [XLEN-1:0] ERR_RDATA   = 32'h0
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            lsu_req_vld,
  input  logic            lsu_req_wen,
  input  logic [2:0]      lsu_req_rwtyp,
  input  logic [XLEN-1:0] lsu_req_addr,
  input  logic [XLEN-1:0] lsu_req_wdata,
  output logic            lsu_req_rdy,
  output logic            lsu_resp_vld,
  output logic [XLEN-1:0] lsu_resp_rdata,
  output logic            lsu_resp_err,
  input  logic            lsu_resp_rdy,
  output logic            lsu_store_err,
  output logic [XLEN-1:0] haddr,
  output logic [1:0]      htrans,
  output logic            hwrite,
  output logic [2:0]      hsize,
  output logic [2:0]      hburst,
  output logic [XLEN-1:0] hwdata,
  input  logic [XLEN-1:0] hrdata,
  input  logic            hready,
  input  logic            hresp
);

  lsu_state_e      state;
  lsu_resp_t       resp;
  logic [2:0]      req_rwtyp;
  logic [XLEN-1:0] req_wdata;
  logic [XLEN-1:0] load_data_c;
  logic            accept_c;
  logic            misalign_c;

  // A new request may only start when the response slot is free or draining now.
  assign lsu_req_rdy    = (state == ST_IDLE) && (!lsu_resp_vld || lsu_resp_rdy);
  assign accept_c       = lsu_req_vld && lsu_req_rdy;
  assign misalign_c     = (CHECK_ALIGN != 0) && is_misaligned(lsu_req_rwtyp, lsu_req_addr[1:0]);
  assign hburst         = HBURST_SINGLE;
  assign lsu_resp_rdata = resp.rdata;
  assign lsu_resp_err   = resp.err;

  core_lsu_load_align u_load_align (
    .hrdata  (hrdata),
    .addr_lo (haddr[1:0]),
    .rwtyp   (req_rwtyp),
    .rdata_c (load_data_c)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state         <= ST_IDLE;
      htrans        <= HTRANS_IDLE;
      haddr         <= '0;
      hwrite        <= 1'b0;
      hsize         <= 3'b000;
      hwdata        <= '0;
      req_rwtyp     <= 3'b000;
      req_wdata     <= '0;
      lsu_resp_vld  <= 1'b0;
      resp          <= '0;
      lsu_store_err <= 1'b0;
    end else begin
      lsu_store_err <= 1'b0;
      if (lsu_resp_vld && lsu_resp_rdy) lsu_resp_vld <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (accept_c) begin
            req_rwtyp <= lsu_req_rwtyp;
            req_wdata <= lsu_req_wdata;
            if (misalign_c) begin
              // Never reaches the bus; report it straight back.
              if (lsu_req_wen) begin
                lsu_store_err <= 1'b1;
              end else begin
                lsu_resp_vld <= 1'b1;
                resp.err     <= 1'b1;
                resp.rdata   <= ERR_RDATA;
              end
            end else begin
              htrans <= HTRANS_NONSEQ;
              haddr  <= lsu_req_addr;
              hwrite <= lsu_req_wen;
              hsize  <= ahb_size(lsu_req_rwtyp);
              state  <= ST_ADDR;
            end
          end
        end

        ST_ADDR: begin
          if (hready) begin
            htrans <= HTRANS_IDLE;
            hwdata <= lane_data(req_rwtyp, req_wdata);
            state  <= ST_DATA;
          end
        end

        ST_DATA: begin
          // The first ERROR cycle has hready low and simply waits here.
          if (hready) begin
            state <= ST_IDLE;
            if (hresp == HRESP_ERROR) begin
              if (hwrite) begin
                lsu_store_err <= 1'b1;
              end else begin
                lsu_resp_vld <= 1'b1;
                resp.err     <= 1'b1;
                resp.rdata   <= ERR_RDATA;
              end
            end else if (!hwrite) begin
              lsu_resp_vld <= 1'b1;
              resp.err     <= 1'b0;
              resp.rdata   <= load_data_c;
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_core_lsu_ahb_master.sv
// Bench for core_lsu_ahb_master: transaction-level model plus AHB slave, directed then random traffic.
module tb_core_lsu_ahb_master;

  localparam logic [31:0] ERR_VAL = 32'hBAD0_0BAD;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        lsu_req_vld = 1'b0;
  logic        lsu_req_wen = 1'b0;
  logic [2:0]  lsu_req_rwtyp = 3'b000;
  logic [31:0] lsu_req_addr = 32'h0;
  logic [31:0] lsu_req_wdata = 32'h0;
  logic        lsu_req_rdy;
  logic        lsu_resp_vld;
  logic [31:0] lsu_resp_rdata;
  logic        lsu_resp_err;
  logic        lsu_resp_rdy = 1'b1;
  logic        lsu_store_err;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [31:0] hwdata;
  logic [31:0] hrdata = 32'h0;
  logic        hready = 1'b1;
  logic        hresp = 1'b0;

  core_lsu_ahb_master #(.CHECK_ALIGN(1), .ERR_RDATA(ERR_VAL)) dut (
    .clk(clk), .rstn(rstn),
    .lsu_req_vld(lsu_req_vld), .lsu_req_wen(lsu_req_wen), .lsu_req_rwtyp(lsu_req_rwtyp),
    .lsu_req_addr(lsu_req_addr), .lsu_req_wdata(lsu_req_wdata), .lsu_req_rdy(lsu_req_rdy),
    .lsu_resp_vld(lsu_resp_vld), .lsu_resp_rdata(lsu_resp_rdata), .lsu_resp_err(lsu_resp_err),
    .lsu_resp_rdy(lsu_resp_rdy), .lsu_store_err(lsu_store_err),
    .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hburst(hburst),
    .hwdata(hwdata), .hrdata(hrdata), .hready(hready), .hresp(hresp)
  );

  initial forever #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
  endtask

  // ---------------- reference model helpers ----------------
  function automatic int unsigned nbytes(input logic [2:0] typ);
    return 32'd1 << (32'(typ) % 4);
  endfunction

  function automatic logic [31:0] lanes(input logic [2:0] typ, input logic [31:0] wd);
    if (nbytes(typ) == 1) return (wd % 32'd256) * 32'h0101_0101;
    if (nbytes(typ) == 2) return (wd % 32'd65536) * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] extract(input logic [2:0] typ, input logic [31:0] addr,
                                          input logic [31:0] rd);
    int unsigned n;
    logic [31:0] v, lim;
    n = nbytes(typ);
    if (n == 4) return rd;
    v   = rd >> (8 * (addr % 4));
    lim = 32'd1 << (8 * n);
    v   = v % lim;
    if (typ < 3'd4 && v >= (lim >> 1)) v = v - lim;
    return v;
  endfunction

  // ---------------- model + slave + compare ----------------
  typedef enum {PH_NONE, PH_ADDR, PH_DATA} phase_e;
  phase_e      ph = PH_NONE;
  bit          armed = 0, after_rst = 0;
  bit          m_resp_vld = 0, m_err = 0, m_serr = 0;
  logic [31:0] m_rdata = 32'h0;
  bit          t_wen = 0;
  logic [2:0]  t_typ = 3'b000;
  logic [31:0] t_addr = 32'h0, t_wdata = 32'h0;
  int          dp_waits = 0;
  bit          dp_err = 0, dp_err_first = 0;
  logic [31:0] dp_rdata = 32'h0;

  bit          rand_slave = 0, rand_rdy = 0;
  int          k_waits = 0, k_err = 0, addr_stall = 0;
  logic [31:0] k_rdata = 32'h0;

  initial begin
    bit exp_rdy;
    forever begin
      @(negedge clk);
      exp_rdy = (ph == PH_NONE) && (!m_resp_vld || lsu_resp_rdy);
      if (armed) begin
        chk("req_rdy", 32'(lsu_req_rdy), 32'(exp_rdy));
        chk("resp_vld", 32'(lsu_resp_vld), 32'(m_resp_vld));
        if (m_resp_vld) begin
          chk("resp_rdata", lsu_resp_rdata, m_rdata);
          chk("resp_err", 32'(lsu_resp_err), 32'(m_err));
        end
        chk("store_err", 32'(lsu_store_err), 32'(m_serr));
        chk("htrans", 32'(htrans), (ph == PH_ADDR) ? 32'd2 : 32'd0);
        chk("hburst", 32'(hburst), 32'd0);
        if (ph == PH_ADDR) begin
          chk("haddr", haddr, t_addr);
          chk("hwrite", 32'(hwrite), 32'(t_wen));
          chk("hsize", 32'(hsize), 32'(t_typ) % 4);
        end
        if (ph == PH_DATA && t_wen) chk("hwdata", hwdata, lanes(t_typ, t_wdata));
        if (after_rst && ph == PH_NONE) begin
          chk("rst_haddr", haddr, 32'd0);
          chk("rst_hwrite", 32'(hwrite), 32'd0);
          chk("rst_hsize", 32'(hsize), 32'd0);
          chk("rst_hwdata", hwdata, 32'd0);
        end
      end

      // Slave: drive the bus inputs for the coming edge.
      if (ph == PH_DATA) begin
        if (dp_waits > 0) begin
          hready = 1'b0; hresp = 1'b0; hrdata = $urandom; dp_waits--;
        end else if (dp_err && dp_err_first) begin
          hready = 1'b0; hresp = 1'b1; hrdata = $urandom; dp_err_first = 0;
        end else begin
          hready = 1'b1; hresp = dp_err; hrdata = dp_rdata;
        end
      end else begin
        hresp  = 1'b0;
        hrdata = $urandom;
        if (addr_stall > 0) begin
          hready = 1'b0; addr_stall--;
        end else begin
          hready = rand_slave ? ($urandom_range(3) != 0) : 1'b1;
        end
      end

      // Advance the model across the coming edge.
      if (!rstn) begin
        ph = PH_NONE; m_resp_vld = 0; m_serr = 0; after_rst = 1; armed = 1;
      end else begin
        m_serr = 0;
        if (m_resp_vld && lsu_resp_rdy) m_resp_vld = 0;
        case (ph)
          PH_NONE: if (lsu_req_vld && exp_rdy) begin
            t_wen = lsu_req_wen; t_typ = lsu_req_rwtyp;
            t_addr = lsu_req_addr; t_wdata = lsu_req_wdata;
            if (t_addr % nbytes(t_typ) != 0) begin
              if (t_wen) m_serr = 1;
              else begin m_resp_vld = 1; m_err = 1; m_rdata = ERR_VAL; end
            end else begin
              ph = PH_ADDR; after_rst = 0;
            end
          end
          PH_ADDR: if (hready) begin
            ph           = PH_DATA;
            dp_waits     = rand_slave ? int'($urandom_range(2)) : k_waits;
            dp_err       = rand_slave ? ($urandom_range(7) == 0) : (k_err != 0);
            dp_err_first = 1;
            dp_rdata     = rand_slave ? $urandom : k_rdata;
          end
          default: if (hready) begin
            ph = PH_NONE;
            if (hresp) begin
              if (t_wen) m_serr = 1;
              else begin m_resp_vld = 1; m_err = 1; m_rdata = ERR_VAL; end
            end else if (!t_wen) begin
              m_resp_vld = 1; m_err = 0; m_rdata = extract(t_typ, t_addr, hrdata);
            end
          end
        endcase
      end
    end
  end

  // Consumer ready, randomised when enabled.
  initial forever begin
    @(posedge clk); #2;
    if (rand_rdy) lsu_resp_rdy = ($urandom_range(3) != 0);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  task automatic issue(input bit wen, input logic [2:0] typ, input logic [31:0] addr,
                       input logic [31:0] wd);
    int n;
    n = 0;
    @(posedge clk); #1;
    lsu_req_vld = 1'b1; lsu_req_wen = wen; lsu_req_rwtyp = typ;
    lsu_req_addr = addr; lsu_req_wdata = wd;
    do begin @(negedge clk); n++; end while (!lsu_req_rdy && n < 64);
    if (!lsu_req_rdy) begin
      n_chk++;
      $display("FAIL req_accept: rdy still 0 after %0d cycles, expected 1", n);
    end
    @(posedge clk); #1;
    lsu_req_vld = 1'b0;
  endtask

  task automatic load_expect(input string nm, input logic [2:0] typ, input logic [31:0] addr,
                             input logic [31:0] exp);
    issue(1'b0, typ, addr, 32'h0);
    repeat (3) @(negedge clk);
    chk({nm, "_vld"}, 32'(lsu_resp_vld), 32'd1);
    chk({nm, "_rdata"}, lsu_resp_rdata, exp);
    chk({nm, "_err"}, 32'(lsu_resp_err), 32'd0);
  endtask

  initial begin
    logic [2:0] typ;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;

    // 1: word load, literal latency
    k_rdata = 32'hDEAD_BEEF;
    issue(1'b0, 3'b010, 32'h1000, 32'h0);
    @(negedge clk);
    chk("t1_htrans", 32'(htrans), 32'd2);
    chk("t1_haddr", haddr, 32'h1000);
    chk("t1_hsize", 32'(hsize), 32'd2);
    @(negedge clk);
    chk("t1_dphase_htrans", 32'(htrans), 32'd0);
    chk("t1_noresp_yet", 32'(lsu_resp_vld), 32'd0);
    @(negedge clk);
    chk("t1_vld", 32'(lsu_resp_vld), 32'd1);
    chk("t1_rdata", lsu_resp_rdata, 32'hDEAD_BEEF);
    chk("t1_err", 32'(lsu_resp_err), 32'd0);

    // 2: byte/half extraction
    k_rdata = 32'h80FF_0000;
    load_expect("t2_lb", 3'b000, 32'h1003, 32'hFFFF_FF80);
    load_expect("t2_lbu", 3'b100, 32'h1003, 32'h0000_0080);
    load_expect("t2_lhu", 3'b101, 32'h1002, 32'h0000_80FF);

    // 3: byte store with address-phase stall
    issue(1'b1, 3'b000, 32'h2001, 32'h1234_56AB);
    addr_stall = 2;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t3_htrans_held", 32'(htrans), 32'd2);
      chk("t3_haddr_held", haddr, 32'h2001);
    end
    chk("t3_hwrite", 32'(hwrite), 32'd1);
    chk("t3_hsize", 32'(hsize), 32'd0);
    @(negedge clk);
    chk("t3_hwdata", hwdata, 32'hABAB_ABAB);
    chk("t3_noresp", 32'(lsu_resp_vld), 32'd0);
    @(negedge clk);
    chk("t3_rdy_back", 32'(lsu_req_rdy), 32'd1);
    chk("t3_noresp2", 32'(lsu_resp_vld), 32'd0);

    // 4: misaligned load and store
    issue(1'b0, 3'b001, 32'h3001, 32'h0);
    @(negedge clk);
    chk("t4_htrans_idle", 32'(htrans), 32'd0);
    chk("t4_vld", 32'(lsu_resp_vld), 32'd1);
    chk("t4_err", 32'(lsu_resp_err), 32'd1);
    chk("t4_rdata", lsu_resp_rdata, ERR_VAL);
    issue(1'b1, 3'b010, 32'h3002, 32'h5555_AAAA);
    @(negedge clk);
    chk("t4_serr", 32'(lsu_store_err), 32'd1);
    chk("t4_s_htrans", 32'(htrans), 32'd0);
    @(negedge clk);
    chk("t4_serr_pulse", 32'(lsu_store_err), 32'd0);

    // 5: AHB ERROR on a load, response held under backpressure
    @(posedge clk); #1;
    lsu_resp_rdy = 1'b0;
    k_err = 1;
    issue(1'b0, 3'b010, 32'h4000, 32'h0);
    repeat (4) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      chk("t5_vld_held", 32'(lsu_resp_vld), 32'd1);
      chk("t5_err", 32'(lsu_resp_err), 32'd1);
      chk("t5_rdata", lsu_resp_rdata, ERR_VAL);
      chk("t5_req_blocked", 32'(lsu_req_rdy), 32'd0);
    end
    @(posedge clk); #1;
    lsu_resp_rdy = 1'b1;
    k_err = 0;
    @(negedge clk);
    chk("t5_rdy_release", 32'(lsu_req_rdy), 32'd1);
    @(negedge clk);
    chk("t5_consumed", 32'(lsu_resp_vld), 32'd0);

    // 6: reset during the data phase of a load
    k_waits = 4;
    issue(1'b0, 3'b010, 32'h6000, 32'h0);
    @(negedge clk);
    @(negedge clk);
    chk("t6_in_dphase", 32'(htrans), 32'd0);
    @(posedge clk); #1;
    rstn = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("t6_rst_htrans", 32'(htrans), 32'd0);
    chk("t6_rst_noresp", 32'(lsu_resp_vld), 32'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    k_waits = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t6_no_late_resp", 32'(lsu_resp_vld), 32'd0);
    end
    k_rdata = 32'h1122_3344;
    load_expect("t6_after", 3'b010, 32'h6004, 32'h1122_3344);

    // Random traffic against the model
    rand_slave = 1;
    rand_rdy   = 1;
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(4))
        0:       typ = 3'b000;
        1:       typ = 3'b001;
        2:       typ = 3'b010;
        3:       typ = 3'b100;
        default: typ = 3'b101;
      endcase
      issue(1'($urandom_range(1)), typ, 32'h8000 + $urandom_range(255), $urandom);
      repeat ($urandom_range(2)) @(posedge clk);
    end
    @(posedge clk); #1;
    rand_rdy = 0;
    lsu_resp_rdy = 1'b1;
    repeat (20) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
